// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and constants for the UART transmit buffer.
package uart_tx_buffer_pkg;

    typedef enum logic [1:0] {UART_IDLE, UART_START, UART_DATA, UART_STOP} uart_state_t;

    // Bits per serial frame payload; the 7-bit character is zero-extended to this.
    localparam int UART_DATA_BITS = 8;
    localparam int UART_CHAR_BITS = 7;

endpackage

// File: rtl/uart_tx_buffer_char_fifo.sv
// Character FIFO: power-of-two depth, free-running wrapping pointers,
// separate occupancy counter, combinational head on dout.
module char_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CNT_FULL);
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot a push into a full FIFO needs.
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// UART transmit buffer: queues non-zero CPU characters and sends them as
// 8N1 frames, back to back when the queue has more waiting.
//
// state      | meaning
// -----------+----------------------------------------------------------
// UART_IDLE  | line high, waiting for a queued character
// UART_START | start bit (0) for CLKS_PER_BIT cycles
// UART_DATA  | data bits LSB first, CLKS_PER_BIT cycles each
// UART_STOP  | stop bit (1); last cycle pops the next character if any
import uart_tx_buffer_pkg::*;

module uart_tx_buffer #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [6:0]                      char_in,
    output logic                            serial_out,
    output logic                            busy,
    output logic                            overflow,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(UART_DATA_BITS);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(UART_DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    uart_state_t               state;
    logic [BAUD_W-1:0]         baud_cnt;
    logic [BIT_W-1:0]          bit_idx;
    logic [UART_DATA_BITS-1:0] shift_reg;

    logic                      push_req;
    logic                      pop;
    logic                      baud_done;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [UART_CHAR_BITS-1:0] fifo_dout;

    assign push_req  = (char_in != '0);
    assign baud_done = (baud_cnt == BAUD_LAST);
    // Pops happen from IDLE, or on the final stop-bit cycle for gapless frames.
    assign pop = !fifo_empty &&
                 ((state == UART_IDLE) || ((state == UART_STOP) && baud_done));
    assign busy = (state != UART_IDLE) || (fifo_count != '0);

    char_fifo #(
        .WIDTH (UART_CHAR_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop),
        .din   (char_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Serializer: state, baud timing, bit index, shift register and line output.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= UART_IDLE;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            serial_out <= 1'b1;
        end else begin
            case (state)
                UART_IDLE: begin
                    serial_out <= 1'b1;
                    baud_cnt   <= '0;
                    if (pop) begin
                        shift_reg  <= {1'b0, fifo_dout};
                        bit_idx    <= '0;
                        serial_out <= 1'b0;
                        state      <= UART_START;
                    end
                end
                UART_START: begin
                    if (baud_done) begin
                        baud_cnt   <= '0;
                        serial_out <= shift_reg[0];
                        state      <= UART_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                UART_DATA: begin
                    if (baud_done) begin
                        baud_cnt  <= '0;
                        shift_reg <= shift_reg >> 1;
                        if (bit_idx == BIT_LAST) begin
                            serial_out <= 1'b1;
                            state      <= UART_STOP;
                        end else begin
                            bit_idx    <= bit_idx + BIT_ONE;
                            serial_out <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                UART_STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (pop) begin
                            shift_reg  <= {1'b0, fifo_dout};
                            bit_idx    <= '0;
                            serial_out <= 1'b0;
                            state      <= UART_START;
                        end else begin
                            serial_out <= 1'b1;
                            state      <= UART_IDLE;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: begin
                    serial_out <= 1'b1;
                    baud_cnt   <= '0;
                    state      <= UART_IDLE;
                end
            endcase
        end
    end

    // Sticky drop flag: a push into a full FIFO with no same-edge pop is lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (push_req && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: stimulus queues expected characters,
// a line monitor decodes every frame and compares against the queue head.
module tb_uart_tx_buffer;

    localparam int C  = 4;
    localparam int D  = 8;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    char_in = '0;
    logic          serial_out;
    logic          busy;
    logic          overflow;
    logic [CW-1:0] fifo_count;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    logic [6:0] exp_q[$];
    int         frame_starts[$];

    uart_tx_buffer #(
        .CLKS_PER_BIT (C),
        .FIFO_DEPTH   (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .char_in    (char_in),
        .serial_out (serial_out),
        .busy       (busy),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < budget) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        check(name, int'(k < budget), 1);
    endtask

    // Line monitor: every cycle of a frame must hold its slot value.
    initial begin : monitor
        logic [7:0] rx;
        logic [6:0] exp_c;
        logic       cur;
        bit         good;
        bit         aborted;
        int         slot;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && serial_out === 1'b0) begin
                frame_starts.push_back(cyc);
                rx = '0;
                good = 1'b1;
                aborted = 1'b0;
                cur = 1'b0;
                for (int s = 0; s < 10 * C; s++) begin
                    if (s != 0) @(negedge clk);
                    if (reset !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    slot = s / C;
                    if (s % C == 0) begin
                        cur = serial_out;
                        if (slot >= 1 && slot <= 8) rx[slot-1] = serial_out;
                    end else if (serial_out !== cur) begin
                        good = 1'b0;
                    end
                    if (slot == 0 && serial_out !== 1'b0) good = 1'b0;
                    if (slot == 9 && serial_out !== 1'b1) good = 1'b0;
                end
                if (!aborted) begin
                    check("frame_shape", int'(good), 1);
                    if (exp_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_frame: got %02h, none expected", rx);
                    end else begin
                        exp_c = exp_q.pop_front();
                        check("rx_char", int'(rx), int'({1'b0, exp_c}));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int k;
        int peak;
        int fs0;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_serial", int'(serial_out), 1);
        check("rst_count", int'(fifo_count), 0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_serial", int'(serial_out), 1);
            check("idle_busy", int'(busy), 0);
            check("idle_overflow", int'(overflow), 0);
            check("idle_count", int'(fifo_count), 0);
        end

        // Single character 0x41
        char_in = 7'h41;
        exp_q.push_back(7'h41);
        @(negedge clk);
        char_in = '0;
        check("single_count1", int'(fifo_count), 1);
        check("single_line_high", int'(serial_out), 1);
        check("single_busy", int'(busy), 1);
        @(negedge clk);
        check("single_count0", int'(fifo_count), 0);
        check("single_start", int'(serial_out), 0);
        k = 0;
        while (busy && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("single_frame_len", k, 40);
        wait_drain("single_drain", 200);

        // Back-to-back 0x48, 0x49
        fs0 = frame_starts.size();
        char_in = 7'h48;
        exp_q.push_back(7'h48);
        @(negedge clk);
        peak = int'(fifo_count);
        char_in = 7'h49;
        exp_q.push_back(7'h49);
        @(negedge clk);
        char_in = '0;
        k = 0;
        while (busy && k < 300) begin
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
            @(negedge clk);
            k++;
        end
        check("b2b_peak", peak, 1);
        wait_drain("b2b_drain", 200);
        check("b2b_frames", frame_starts.size() - fs0, 2);
        if (frame_starts.size() - fs0 == 2)
            check("b2b_gap", frame_starts[fs0+1] - frame_starts[fs0], 40);

        // Overflow: 10 consecutive pushes into depth 8
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            char_in = 7'(i);
            if (i <= 9) exp_q.push_back(7'(i));
            @(negedge clk);
            if (i == 9) check("ovf_before", int'(overflow), 0);
            if (i == 10) begin
                check("ovf_set", int'(overflow), 1);
                check("ovf_count", int'(fifo_count), 8);
            end
        end
        char_in = '0;
        wait_drain("ovf_drain", 9 * 40 + 60);
        check("ovf_sticky", int'(overflow), 1);

        // Push on the STOP-exit pop edge while full
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            char_in = 7'(i);
            exp_q.push_back(7'(i));
            @(negedge clk);
        end
        char_in = '0;
        check("full_count", int'(fifo_count), 8);
        repeat (32) @(negedge clk);
        check("full_before_pop", int'(fifo_count), 8);
        char_in = 7'h0B;
        exp_q.push_back(7'h0B);
        @(negedge clk);
        char_in = '0;
        check("pushpop_count", int'(fifo_count), 8);
        check("pushpop_ovf", int'(overflow), 0);
        wait_drain("pushpop_drain", 10 * 40 + 60);
        check("pushpop_ovf_end", int'(overflow), 0);

        // Reset mid-frame during DATA bit 3 of 0x55, with 0x66 queued
        char_in = 7'h55;
        @(negedge clk);
        char_in = 7'h66;
        @(negedge clk);
        char_in = '0;
        check("mid_start", int'(serial_out), 0);
        repeat (17) @(negedge clk);
        check("mid_bit3", int'(serial_out), 0);
        check("mid_count", int'(fifo_count), 1);
        exp_q.delete();
        #1 reset = 1'b0;
        #1;
        check("mid_rst_serial", int'(serial_out), 1);
        check("mid_rst_count", int'(fifo_count), 0);
        check("mid_rst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        char_in = 7'h5A;
        exp_q.push_back(7'h5A);
        @(negedge clk);
        char_in = '0;
        wait_drain("post_rst_drain", 200);
        check("post_rst_ovf", int'(overflow), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
